// File: rtl/clint_lite.sv
`default_nettype none
// ============================================================================
// Module   : clint_lite
// Purpose  : Lightweight core-local interruptor.
//            - 64-bit mtime/mtimecmp machine timer, with a prescaler.
//            - Software interrupt bit (msip).
//            - NUM_EXT external interrupt lines. Each line is synchronised
//              and can be edge- or level-sensitive.
//            - Registered mip vector: MSIP = bit 3, MTIP = bit 7, MEIP = bit 11.
//            The timer is built only when CLINT_LITE_TIMER_EN is defined.
//            Without it, the timer registers read as zero and MTIP is 0.
// Revision : 1.0 - initial release
// ============================================================================
module clint_lite #(
    parameter int NUM_EXT  = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_i,
    input  logic               we_i,
    input  logic [4:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ready_o,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    input  logic               irq_ack_i,
    input  logic [4:0]         ack_code_i,
    output logic [31:0]        mip_o
);

    // Word index of each register (addr_i[4:2])
    localparam logic [2:0] c_A_MTIME_LO = 3'd0;
    localparam logic [2:0] c_A_MTIME_HI = 3'd1;
    localparam logic [2:0] c_A_CMP_LO   = 3'd2;
    localparam logic [2:0] c_A_CMP_HI   = 3'd3;
    localparam logic [2:0] c_A_MSIP     = 3'd4;
    localparam logic [2:0] c_A_PEND     = 3'd5;
    localparam logic [2:0] c_A_EN       = 3'd6;
    localparam logic [2:0] c_A_MODE     = 3'd7;

    localparam int         c_MSIP_BIT      = 3;
    localparam int         c_MTIP_BIT      = 7;
    localparam int         c_MEIP_BIT      = 11;
    localparam logic [4:0] c_MEI_CODE      = 5'd11;
    localparam logic [7:0] c_PRESCALE_LAST = 8'(PRESCALE - 1);

    logic [2:0]         w_idx;
    logic               w_wr;
    logic [31:0]        w_rdata;
    logic               w_mtip;
    logic               w_meip;
    logic [31:0]        w_mip_nxt;

    logic               r_msip;
    logic [NUM_EXT-1:0] r_en;
    logic [NUM_EXT-1:0] r_mode;
    logic [NUM_EXT-1:0] r_pend;
    logic [NUM_EXT-1:0] r_sync1;
    logic [NUM_EXT-1:0] r_sync2;
    logic [NUM_EXT-1:0] r_sync3;
    logic [NUM_EXT-1:0] w_rise;
    logic [NUM_EXT-1:0] w_w1c;
    logic [NUM_EXT-1:0] w_ack_sel;
    logic [NUM_EXT-1:0] w_clr;
    logic [NUM_EXT-1:0] w_pend_nxt;
    logic               w_ack_fire;
    logic               r_ready;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mip;

    // The byte-lane bits and the upper write-data bits are not used by every register.
    logic               w_unused;
    assign w_unused = &{1'b0, addr_i[1:0], wdata_i, c_PRESCALE_LAST};

    assign w_idx = addr_i[4:2];
    assign w_wr  = sel_i & we_i;

`ifdef CLINT_LITE_TIMER_EN
    logic [7:0]  r_pcnt;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        w_tick;

    assign w_tick = (r_pcnt == c_PRESCALE_LAST);
    assign w_mtip = (r_mtime >= r_mtimecmp);

    // Prescale counter: wraps to 0 on the cycle that produces a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_pcnt <= 8'd0;
        else if (w_tick) r_pcnt <= 8'd0;
        else             r_pcnt <= r_pcnt + 8'd1;
    end

    // mtime: a bus write to one half wins over the tick; the other half holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mtime <= 64'd0;
        else if (w_wr && (w_idx == c_A_MTIME_LO))
            r_mtime[31:0] <= wdata_i;
        else if (w_wr && (w_idx == c_A_MTIME_HI))
            r_mtime[63:32] <= wdata_i;
        else if (w_tick)
            r_mtime <= r_mtime + 64'd1;
    end

    // mtimecmp: software-written compare value, reset to "never"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mtimecmp <= '1;
        else if (w_wr && (w_idx == c_A_CMP_LO))
            r_mtimecmp[31:0] <= wdata_i;
        else if (w_wr && (w_idx == c_A_CMP_HI))
            r_mtimecmp[63:32] <= wdata_i;
    end
`else
    assign w_mtip = 1'b0;
`endif

    // Software interrupt bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_msip <= 1'b0;
        else if (w_wr && (w_idx == c_A_MSIP))  r_msip <= wdata_i[0];
    end

    // External enable and mode registers; only the implemented bits are stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_mode <= '0;
        end else begin
            if (w_wr && (w_idx == c_A_EN))   r_en   <= wdata_i[NUM_EXT-1:0];
            if (w_wr && (w_idx == c_A_MODE)) r_mode <= wdata_i[NUM_EXT-1:0];
        end
    end

    // Two-flop synchroniser, plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= ext_irq_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_w1c      = (w_wr && (w_idx == c_A_PEND)) ? wdata_i[NUM_EXT-1:0] : '0;
    assign w_ack_fire = irq_ack_i && (ack_code_i == c_MEI_CODE);

    // Select the lowest-index pending bit that is also enabled; the trap ack clears it
    always_comb begin
        logic w_found;
        w_ack_sel = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (r_pend[i] && r_en[i] && !w_found) begin
                w_ack_sel[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign w_clr = w_w1c | (w_ack_fire ? w_ack_sel : '0);

    // Edge bits: a new edge beats a same-cycle clear. Level bits follow the synchronised line.
    assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & r_sync2);

    // Pending register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pend <= '0;
        else        r_pend <= w_pend_nxt;
    end

    // Read multiplexer; unused bit positions return zero
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
`ifdef CLINT_LITE_TIMER_EN
            c_A_MTIME_LO: w_rdata = r_mtime[31:0];
            c_A_MTIME_HI: w_rdata = r_mtime[63:32];
            c_A_CMP_LO:   w_rdata = r_mtimecmp[31:0];
            c_A_CMP_HI:   w_rdata = r_mtimecmp[63:32];
`endif
            c_A_MSIP:     w_rdata = {31'd0, r_msip};
            c_A_PEND:     w_rdata = 32'(r_pend);
            c_A_EN:       w_rdata = 32'(r_en);
            c_A_MODE:     w_rdata = 32'(r_mode);
            default:      w_rdata = 32'd0;
        endcase
    end

    // Bus response: one ready pulse for every strobed cycle, with the read data alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= sel_i;
            if (sel_i) r_rdata <= w_rdata;
        end
    end

    assign w_meip = |(r_pend & r_en);

    // Assemble the mip vector from the current interrupt conditions
    always_comb begin
        w_mip_nxt             = 32'd0;
        w_mip_nxt[c_MSIP_BIT] = r_msip;
        w_mip_nxt[c_MTIP_BIT] = w_mtip;
        w_mip_nxt[c_MEIP_BIT] = w_meip;
    end

    // Registered mip: a condition change shows up one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mip <= 32'd0;
        else        r_mip <= w_mip_nxt;
    end

    assign rdata_o = r_rdata;
    assign ready_o = r_ready;
    assign mip_o   = r_mip;

endmodule
`default_nettype wire

// File: tb/tb_clint_lite.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_lite
// Purpose  : Directed self-checking bench for clint_lite (NUM_EXT=4, PRESCALE=1).
//            Timer scenarios are compiled when CLINT_LITE_TIMER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_lite;

    logic        clk;
    logic        rst_n;
    logic        sel_i;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic [3:0]  ext_irq_i;
    logic        irq_ack_i;
    logic [4:0]  ack_code_i;
    logic [31:0] mip_o;

    int n_checks = 0;
    int n_errors = 0;

    clint_lite #(.NUM_EXT(4), .PRESCALE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_i      (sel_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .ready_o    (ready_o),
        .ext_irq_i  (ext_irq_i),
        .irq_ack_i  (irq_ack_i),
        .ack_code_i (ack_code_i),
        .mip_o      (mip_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each bus task is entered at a negedge and uses exactly one rising edge
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk);
        sel_i = 1'b0; we_i = 1'b0;
        check("write_ready", {31'd0, ready_o}, 32'd1);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        sel_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk);
        sel_i = 1'b0;
        check("read_ready", {31'd0, ready_o}, 32'd1);
        d = rdata_o;
    endtask

    task automatic ack(input logic [4:0] code);
        irq_ack_i = 1'b1; ack_code_i = code;
        @(negedge clk);
        irq_ack_i = 1'b0; ack_code_i = 5'd0;
    endtask

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        rst_n = 1'b0; sel_i = 1'b0; we_i = 1'b0; addr_i = 5'd0; wdata_i = 32'd0;
        ext_irq_i = 4'd0; irq_ack_i = 1'b0; ack_code_i = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ready_o}, 32'd0);
        check("reset_mip", mip_o, 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CLINT_LITE_TIMER_EN
        bus_read(5'h08, rd); check("cmp_lo_reset", rd, 32'hFFFF_FFFF);
        bus_read(5'h0C, rd); check("cmp_hi_reset", rd, 32'hFFFF_FFFF);
`else
        bus_read(5'h08, rd); check("cmp_lo_notimer", rd, 32'd0);
        bus_write(5'h00, 32'h1234_5678);
        bus_read(5'h00, rd); check("mtime_lo_notimer", rd, 32'd0);
`endif

        // Software interrupt
        bus_write(5'h10, 32'd1);
        check("msip_not_yet", {31'd0, mip_o[3]}, 32'd0);
        @(negedge clk);
        check("msip_set", {31'd0, mip_o[3]}, 32'd1);
        ack(5'd3);
        @(negedge clk);
        check("msip_ack3_holds", {31'd0, mip_o[3]}, 32'd1);
        bus_read(5'h10, rd); check("msip_read", rd, 32'd1);
        bus_write(5'h10, 32'd0);
        @(negedge clk);
        check("msip_clear", {31'd0, mip_o[3]}, 32'd0);

        // Edge-mode line 0: pending appears on mip within four cycles
        bus_write(5'h1C, 32'h5);
        bus_write(5'h18, 32'h1);
        ext_irq_i = 4'b0001;
        @(negedge clk);
        ext_irq_i = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("meip_not_yet", {31'd0, mip_o[11]}, 32'd0);
        @(negedge clk);
        check("meip_4cyc", {31'd0, mip_o[11]}, 32'd1);
        bus_read(5'h14, rd); check("pend_edge0", rd, 32'h1);

        // Codes other than 11 leave the pending bit alone
        ack(5'd7);
        @(negedge clk);
        check("meip_ack7_holds", {31'd0, mip_o[11]}, 32'd1);

        ack(5'd11);
        @(negedge clk);
        check("meip_ack11_clr", {31'd0, mip_o[11]}, 32'd0);

        // The acknowledge clears only the lowest enabled pending bit
        bus_write(5'h18, 32'h5);
        ext_irq_i = 4'b0101;
        @(negedge clk);
        ext_irq_i = 4'b0000;
        repeat (3) @(negedge clk);
        bus_read(5'h14, rd); check("pend_two", rd, 32'h5);
        ack(5'd11);
        bus_read(5'h14, rd); check("pend_ack_lowest", rd, 32'h4);

        // A new edge on line 2 in the same cycle as W1C of bit 2: the set wins
        ext_irq_i = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        bus_write(5'h14, 32'h4);
        bus_read(5'h14, rd); check("pend_set_wins", rd, 32'h4);

        // W1C with no edge clears the bit
        bus_write(5'h14, 32'h4);
        bus_read(5'h14, rd); check("pend_w1c", rd, 32'h0);
        ext_irq_i = 4'b0000;

        // Level-mode line 1 follows the line; W1C has no effect on it
        ext_irq_i = 4'b0010;
        repeat (3) @(negedge clk);
        bus_read(5'h14, rd); check("level_high", rd, 32'h2);
        bus_write(5'h14, 32'h2);
        bus_read(5'h14, rd); check("level_w1c_ignored", rd, 32'h2);
        ext_irq_i = 4'b0000;
        repeat (3) @(negedge clk);
        bus_read(5'h14, rd); check("level_low", rd, 32'h0);

        // Unimplemented bits read as zero
        bus_write(5'h18, 32'hFFFF_FFFF);
        bus_read(5'h18, rd); check("en_upper_zero", rd, 32'hF);
        bus_write(5'h1C, 32'hFFFF_FFF0);
        bus_read(5'h1C, rd); check("mode_upper_zero", rd, 32'h0);

`ifdef CLINT_LITE_TIMER_EN
        // MTIP raised on the cycle after mtime reaches 0x10
        bus_write(5'h08, 32'h10);
        bus_write(5'h00, 32'h0);
        bus_write(5'h0C, 32'h0);
        repeat (15) @(negedge clk);
        check("mtip_not_yet", {31'd0, mip_o[7]}, 32'd0);
        @(negedge clk);
        check("mtip_set", {31'd0, mip_o[7]}, 32'd1);

        // Carry from the low half into the high half
        bus_write(5'h08, 32'hFFFF_FFFF);
        bus_write(5'h0C, 32'hFFFF_FFFF);
        bus_write(5'h04, 32'h0);
        bus_write(5'h00, 32'hFFFF_FFF0);
        repeat (28) @(negedge clk);
        bus_read(5'h04, rd); check("mtime_hi_carry", rd, 32'h1);
        bus_read(5'h00, rd); check("mtime_lo_after", rd, 32'd13);
        // A write to mtime_lo on a tick cycle wins
        bus_write(5'h00, 32'd5);
        bus_read(5'h00, rd); check("mtime_lo_write_wins", rd, 32'd5);
        bus_read(5'h04, rd); check("mtime_hi_holds", rd, 32'h1);
`endif

        // Reset asserted while a read response is being presented
        bus_write(5'h10, 32'd1);
        @(negedge clk);
        check("pre_reset_msip", {31'd0, mip_o[3]}, 32'd1);
        sel_i = 1'b1; we_i = 1'b0; addr_i = 5'h10;
        #6;
        check("pre_reset_ready", {31'd0, ready_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midread_ready", {31'd0, ready_o}, 32'd0);
        check("midread_mip", mip_o, 32'd0);
        sel_i = 1'b0;
        @(negedge clk);
        check("midread_ready_held", {31'd0, ready_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef CLINT_LITE_TIMER_EN
        bus_read(5'h08, rd); check("cmp_after_reset", rd, 32'hFFFF_FFFF);
`else
        bus_read(5'h08, rd); check("cmp_after_reset_notimer", rd, 32'd0);
`endif
        bus_read(5'h10, rd); check("msip_after_reset", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
